// File: rtl/rs_syndrome_if.sv
// rs_syndrome_if: symbol stream in, syndrome set out, for the RS(255,239)
// receive front end.
//   master : symbol source; drives din/din_valid/din_sop and observes results
//   slave  : syndrome block; consumes symbols and drives syn/syn_valid/
//            syn_nz/frame_err
// syn carries 16 syndromes, S_j in bits [8j+7:8j].
interface rs_syndrome_if;
    logic [7:0]   din;
    logic         din_valid;
    logic         din_sop;
    logic [127:0] syn;
    logic         syn_valid;
    logic         syn_nz;
    logic         frame_err;

    modport master (
        output din, din_valid, din_sop,
        input  syn, syn_valid, syn_nz, frame_err
    );

    modport slave (
        input  din, din_valid, din_sop,
        output syn, syn_valid, syn_nz, frame_err
    );
endinterface

// File: rtl/rs_syndrome.sv
// rs_syndrome: RS(255,239) syndrome calculator over GF(2^8), poly 0x11D.
// Symbols arrive highest degree first; accumulator j runs Horner's rule
// with the constant alpha^j, so after N symbols acc_j = r(alpha^j).
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous, active-high reset
//   bus  - rs_syndrome_if.slave: din/din_valid/din_sop in;
//          syn (16 x 8 bit), syn_valid, syn_nz, frame_err out (all registered)
module rs_syndrome #(
    parameter int N    = 255,
    parameter int NSYN = 16
) (
    input  logic          clk,
    input  logic          rst,
    rs_syndrome_if.slave  bus
);

    localparam int                CNT_W    = $clog2(N);
    localparam logic [CNT_W-1:0]  CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(N - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FRAME = 1'b1
    } state_t;

    // Multiply by alpha: shift left, fold x^8 back as x^4+x^3+x^2+1.
    function automatic logic [7:0] mul_alpha(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1d : 8'h00);
    endfunction

    // Multiply by alpha^pw; pw is always an elaboration constant here, so
    // this collapses to a fixed XOR network.
    function automatic logic [7:0] mul_alpha_pow(input logic [7:0] x,
                                                 input int unsigned pw);
        logic [7:0] r;
        r = x;
        for (int unsigned k = 0; k < pw; k++) begin
            r = mul_alpha(r);
        end
        return r;
    endfunction

    state_t                      state_r, state_s;
    logic [CNT_W-1:0]            cnt_r, cnt_s;
    logic [NSYN-1:0][7:0]        acc_r, acc_s;
    logic [NSYN-1:0][7:0]        horner_s;
    logic [NSYN-1:0][7:0]        syn_r, syn_s;
    logic                        syn_nz_r, syn_nz_s;
    logic                        syn_valid_r, syn_valid_s;
    logic                        frame_err_r, frame_err_s;

    // One Horner step per syndrome: acc_j * alpha^j + din.
    for (genvar j = 0; j < NSYN; j++) begin : g_horner
        assign horner_s[j] = mul_alpha_pow(acc_r[j], j) ^ bus.din;
    end

    // Next-state and next-output logic for frame tracking and accumulation.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        acc_s       = acc_r;
        syn_s       = syn_r;
        syn_nz_s    = syn_nz_r;
        syn_valid_s = 1'b0;
        frame_err_s = 1'b0;
        if (bus.din_valid) begin
            if (bus.din_sop) begin
                // A sop inside a running frame drops that frame and flags it.
                frame_err_s = (state_r == ST_FRAME) && (cnt_r != CNT_ZERO);
                acc_s       = {NSYN{bus.din}};
                cnt_s       = CNT_ONE;
                state_s     = ST_FRAME;
            end else if (state_r == ST_IDLE) begin
                // Stray symbol outside a frame: flag it, change nothing else.
                frame_err_s = 1'b1;
            end else if (cnt_r == CNT_LAST) begin
                syn_s       = horner_s;
                syn_nz_s    = |horner_s;
                syn_valid_s = 1'b1;
                cnt_s       = CNT_ZERO;
                state_s     = ST_IDLE;
            end else begin
                acc_s = horner_s;
                cnt_s = cnt_r + CNT_ONE;
            end
        end else begin
            // Gap cycle: everything holds.
            state_s = state_r;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= CNT_ZERO;
            acc_r       <= '0;
            syn_r       <= '0;
            syn_nz_r    <= 1'b0;
            syn_valid_r <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            acc_r       <= acc_s;
            syn_r       <= syn_s;
            syn_nz_r    <= syn_nz_s;
            syn_valid_r <= syn_valid_s;
            frame_err_r <= frame_err_s;
        end
    end

    assign bus.syn       = syn_r;
    assign bus.syn_nz    = syn_nz_r;
    assign bus.syn_valid = syn_valid_r;
    assign bus.frame_err = frame_err_r;

endmodule

// File: tb/tb_rs_syndrome.sv
module tb_rs_syndrome;
    localparam int N = 255;
    typedef logic [7:0] cw_t [0:N-1];   // indexed by polynomial degree

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rs_syndrome_if bus ();
    rs_syndrome #(.N(N), .NSYN(16)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    // Output monitor: record every syn_valid and frame_err cycle.
    logic [127:0] vq_syn[$];
    logic         vq_nz[$];
    int           vq_cyc[$];
    int           fq_cyc[$];
    always @(negedge clk) begin
        if (bus.syn_valid === 1'b1) begin
            vq_syn.push_back(bus.syn);
            vq_nz.push_back(bus.syn_nz);
            vq_cyc.push_back(cyc);
        end
        if (bus.frame_err === 1'b1) fq_cyc.push_back(cyc);
    end

    logic [7:0] alog [0:254];
    logic [7:0] gen  [0:16];

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1d) : (aa << 1);
        end
        return p;
    endfunction

    // Direct evaluation S_j = sum_d r_d * alpha^(j*d).
    function automatic logic [127:0] ref_syn(input cw_t c);
        logic [127:0] s = '0;
        for (int j = 0; j < 16; j++) begin
            logic [7:0] acc = 8'h00;
            for (int d = 0; d < N; d++) acc = acc ^ gf_mul(c[d], alog[(j * d) % 255]);
            s[8*j +: 8] = acc;
        end
        return s;
    endfunction

    // Random codeword as message(x) * g(x).
    function automatic cw_t make_codeword();
        cw_t c;
        logic [7:0] m [0:238];
        for (int d = 0; d < 239; d++) m[d] = 8'($urandom);
        for (int d = 0; d < N; d++) c[d] = 8'h00;
        for (int d = 0; d < 239; d++)
            for (int k = 0; k <= 16; k++) c[d + k] = c[d + k] ^ gf_mul(m[d], gen[k]);
        return c;
    endfunction

    function automatic cw_t zero_cw();
        cw_t c;
        for (int d = 0; d < N; d++) c[d] = 8'h00;
        return c;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Send the first `count` symbols of c (highest degree first), sop on the first.
    task automatic send_syms(input cw_t c, input int count, input int duty,
                             output int first_cyc, output int last_cyc);
        int k = 0;
        first_cyc = 0;
        last_cyc = 0;
        while (k < count) begin
            @(negedge clk);
            if (duty >= 100 || $urandom_range(99, 0) < duty) begin
                bus.din       = c[N-1-k];
                bus.din_valid = 1'b1;
                bus.din_sop   = (k == 0);
                if (k == 0) first_cyc = cyc;
                last_cyc = cyc;
                k++;
            end else begin
                bus.din       = 8'($urandom);
                bus.din_valid = 1'b0;
                bus.din_sop   = 1'($urandom);
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.din_valid = 1'b0;
            bus.din_sop   = 1'b0;
            bus.din       = 8'h00;
        end
    endtask

    task automatic clear_q();
        vq_syn.delete(); vq_nz.delete(); vq_cyc.delete(); fq_cyc.delete();
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_syn"}, bus.syn, 128'd0);
        check({tag, "_valid"}, 128'(bus.syn_valid), 128'd0);
        check({tag, "_nz"}, 128'(bus.syn_nz), 128'd0);
        check({tag, "_ferr"}, 128'(bus.frame_err), 128'd0);
    endtask

    // Check exactly one syn_valid with expected syndromes and latency.
    task automatic check_one_frame(input string tag, input cw_t c, input int last_cyc);
        logic [127:0] exp_s;
        exp_s = ref_syn(c);
        check({tag, "_count"}, 128'(vq_syn.size()), 128'd1);
        if (vq_syn.size() >= 1) begin
            check({tag, "_syn"}, vq_syn[0], exp_s);
            check({tag, "_nz"}, 128'(vq_nz[0]), 128'(|exp_s));
            check({tag, "_lat"}, 128'(vq_cyc[0]), 128'(last_cyc + 1));
        end
    endtask

    initial begin
        cw_t c, c1, c2, c3;
        int  fc, lc, fc1, lc1, lc2, lc3, c_err;
        logic [127:0] ones;
        logic [127:0] e1, e3;

        alog[0] = 8'h01;
        for (int i = 1; i < 255; i++) alog[i] = gf_mul(alog[i-1], 8'h02);
        for (int k = 0; k <= 16; k++) gen[k] = 8'h00;
        gen[0] = 8'h01;
        for (int j = 0; j < 16; j++)
            for (int k = 16; k >= 0; k--)
                gen[k] = gf_mul(gen[k], alog[j]) ^ ((k > 0) ? gen[k-1] : 8'h00);
        for (int j = 0; j < 16; j++) ones[8*j +: 8] = 8'h01;

        rst = 1'b1;
        bus.din = 8'h00; bus.din_valid = 1'b0; bus.din_sop = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_outputs_zero("reset");

        // Stray symbol without sop after reset.
        clear_q();
        @(negedge clk);
        c_err = cyc;
        bus.din = 8'h55; bus.din_valid = 1'b1; bus.din_sop = 1'b0;
        idle(3);
        check("nosop_ferr_count", 128'(fq_cyc.size()), 128'd1);
        if (fq_cyc.size() >= 1) check("nosop_ferr_lat", 128'(fq_cyc[0]), 128'(c_err + 1));
        check("nosop_no_valid", 128'(vq_syn.size()), 128'd0);

        // Valid codeword, error in the last symbol (degree 0).
        clear_q();
        c = make_codeword();
        c[0] = c[0] ^ 8'h01;
        send_syms(c, N, 100, fc, lc);
        idle(3);
        check_one_frame("lasterr", c, lc);
        check("lasterr_ones", bus.syn, ones);
        check("lasterr_no_ferr", 128'(fq_cyc.size()), 128'd0);

        // Reset after 100 symbols of a frame.
        clear_q();
        c = make_codeword();
        send_syms(c, 100, 100, fc, lc);
        @(negedge clk);
        bus.din_valid = 1'b0; bus.din_sop = 1'b0;
        rst = 1'b1;
        #1;
        check_outputs_zero("midrst_asserted");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle(2);
        check_outputs_zero("midrst_released");
        check("midrst_no_valid", 128'(vq_syn.size()), 128'd0);

        // All-zero codeword.
        clear_q();
        c = zero_cw();
        send_syms(c, N, 100, fc, lc);
        idle(3);
        check_one_frame("zero", c, lc);
        check("zero_no_ferr", 128'(fq_cyc.size()), 128'd0);

        // Error in the first symbol (degree 254).
        clear_q();
        c = zero_cw();
        c[N-1] = 8'h01;
        send_syms(c, N, 100, fc, lc);
        idle(3);
        check_one_frame("firsterr", c, lc);
        check("firsterr_s0", 128'(bus.syn[7:0]), 128'h01);
        check("firsterr_s1", 128'(bus.syn[15:8]), 128'h8e);

        // Gapped input at ~30% valid duty.
        clear_q();
        c = make_codeword();
        c[$urandom_range(254, 0)] ^= 8'($urandom_range(255, 1));
        c[$urandom_range(254, 0)] ^= 8'($urandom_range(255, 1));
        send_syms(c, N, 30, fc, lc);
        idle(3);
        check_one_frame("gapped", c, lc);

        // Three back-to-back codewords: error, clean, error.
        clear_q();
        c1 = make_codeword();
        c1[$urandom_range(254, 0)] ^= 8'($urandom_range(255, 1));
        c2 = make_codeword();
        c3 = make_codeword();
        c3[$urandom_range(254, 0)] ^= 8'($urandom_range(255, 1));
        c3[$urandom_range(254, 0)] ^= 8'($urandom_range(255, 1));
        e1 = ref_syn(c1);
        e3 = ref_syn(c3);
        send_syms(c1, N, 100, fc, lc1);
        send_syms(c2, N, 100, fc, lc2);
        send_syms(c3, N, 100, fc, lc3);
        idle(3);
        check("b2b_count", 128'(vq_syn.size()), 128'd3);
        if (vq_syn.size() >= 3) begin
            check("b2b_syn1", vq_syn[0], e1);
            check("b2b_syn2", vq_syn[1], 128'd0);
            check("b2b_syn3", vq_syn[2], e3);
            check("b2b_nz1", 128'(vq_nz[0]), 128'd1);
            check("b2b_nz2", 128'(vq_nz[1]), 128'd0);
            check("b2b_nz3", 128'(vq_nz[2]), 128'd1);
            check("b2b_lat1", 128'(vq_cyc[0]), 128'(lc1 + 1));
            check("b2b_gap12", 128'(vq_cyc[1] - vq_cyc[0]), 128'd255);
            check("b2b_gap23", 128'(vq_cyc[2] - vq_cyc[1]), 128'd255);
        end
        check("b2b_no_ferr", 128'(fq_cyc.size()), 128'd0);

        // sop arriving at symbol 50 of a running frame.
        clear_q();
        c1 = make_codeword();
        c = make_codeword();
        c[$urandom_range(254, 0)] ^= 8'($urandom_range(255, 1));
        send_syms(c1, 50, 100, fc, lc);
        send_syms(c, N, 100, fc1, lc);
        idle(3);
        check("abort_ferr_count", 128'(fq_cyc.size()), 128'd1);
        if (fq_cyc.size() >= 1) check("abort_ferr_lat", 128'(fq_cyc[0]), 128'(fc1 + 1));
        check_one_frame("abort_newframe", c, lc);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/rs_syndrome.md
# rs_syndrome

Receive-side front end of the RS(255,239) datapath over GF(2^8). It accepts one codeword symbol per valid cycle, highest-degree symbol first, in the same order the encoder emits them. It computes the 16 syndromes S_j = r(alpha^j), j = 0..15, using per-syndrome Horner accumulators. At each codeword boundary it presents the syndrome set and a nonzero flag to the downstream key-equation solver.

## Interface
Parameters:
- N, 255, codeword length in symbols (shortened codes: 17..255); 239 data + 16 parity when N = 255.
- NSYN, 16, number of syndromes (2t); fixed at 16 in this revision.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous and active-high; clears all state.
- din  input  8  received symbol.
- din_valid  input  1  din is valid this cycle; gaps (low) are allowed anywhere in a codeword.
- din_sop  input  1  qualified by din_valid; marks the first symbol of a codeword.
- syn  output  128  syndrome set; S_j occupies bits [8j+7:8j].
- syn_valid  output  1  one-cycle pulse; syn and syn_nz are new this cycle.
- syn_nz  output  1  OR of all syndrome bits; meaningful only with syn_valid.
- frame_err  output  1  one-cycle pulse on a codeword-framing violation.

## Operation
- Field: GF(2^8), primitive polynomial x^8+x^4+x^3+x^2+1 (0x11D), alpha = 0x02. First consecutive root is alpha^0, matching the encoder generator.
- Multipliers: accumulator j multiplies by the constant alpha^j. Each multiplier is a fixed XOR network; there are no general multipliers and no lookup tables.
- Symbol counter cnt, range 0..N-1, with an in_frame flag.
- Accepted symbol = cycle with din_valid = 1. Only accepted symbols change state; while din_valid = 0, accumulators, cnt and outputs hold.
- First symbol of a frame (din_sop = 1):
  - acc_j <= din for all j; the old contents are discarded.
  - cnt <= 1, in_frame <= 1.
- Subsequent symbol while in_frame and cnt < N-1:
  - acc_j <= mul_alpha_j(acc_j) ^ din.
  - cnt <= cnt + 1.
- Last symbol (in_frame, cnt == N-1, din_sop = 0):
  - syn register <= mul_alpha_j(acc_j) ^ din, for all j.
  - syn_nz <= OR of those next values.
  - syn_valid <= 1 for one cycle.
  - in_frame <= 0, cnt <= 0.
- Back-to-back frames: the symbol accepted in the cycle right after the last symbol may carry din_sop. No idle cycle is required.
- Framing errors, each producing a frame_err pulse the next cycle:
  - din_sop while in_frame and cnt != 0: the partial frame is dropped and the new frame starts normally with this symbol. No syn_valid is produced for the dropped frame.
  - din_valid with din_sop = 0 while not in_frame: the symbol is ignored and no state changes.
- syn and syn_nz hold their last values until the next syn_valid.
- Reset (any time, including mid-frame) clears:
  - acc_j = 0, cnt = 0, in_frame = 0.
  - syn = 0, syn_valid = 0, syn_nz = 0, frame_err = 0.
  - The partial frame is lost. The first symbol after reset deasserts must carry din_sop.

## Timing
- Throughput: one symbol per clock sustained, with no backpressure.
- Latency: syn_valid is high in the cycle immediately after the clock edge that accepts the Nth symbol, i.e. one register stage.
- Minimum frame time: N cycles. The gap between syn_valid pulses is at least N cycles.
- frame_err has the same one-cycle registered latency as syn_valid.
- A syn_valid and a frame_err in the same cycle cannot occur: a last symbol never carries sop.
- Critical path: one constant-alpha^15 XOR network + 8-bit XOR + 128-input OR for syn_nz. syn_nz may be pipelined only if syn_valid is delayed to match.

## Test plan
- Reset and idle:
  - Assert rst mid-frame (after 100 symbols), then release.
  - Required: all outputs 0.
  - Then send a full all-zero codeword with sop. Required: syn_valid once, syn = 0, syn_nz = 0.
- Single error in the last symbol:
  - Valid encoder codeword with symbol 254 XORed by 0x01.
  - Required: every S_j = 0x01, syn_nz = 1.
- Single error in the first symbol:
  - All-zero codeword with symbol 0 = 0x01.
  - Required: S_0 = 0x01, S_1 = alpha^254 = 0x8E, S_j = alpha^(254j) per reference model.
- Gapped input:
  - Random din_valid duty of 30%.
  - Required: syndromes identical to the gapless run, with syn_valid one cycle after the 255th accepted symbol.
- Back-to-back frames:
  - Three codewords with no idle cycles, codeword 2 clean, codewords 1 and 3 with random errors.
  - Required: three syn_valid pulses exactly 255 cycles apart; syn_nz = 1, 0, 1.
- Framing violations:
  - Case 1: sop at symbol 50 of a frame. Required: frame_err pulse; the new frame completes normally.
  - Case 2: valid without sop after reset. Required: frame_err pulse, no state change.
